fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: a PC register that addresses a combinational
// program memory and a 2-entry {instr, pc} queue feeding decode.
module fetch_queue #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 27,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  nreset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  fetch_en,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [31:0]           out_pc
);

  localparam int DEPTH = 2;

  logic [31:0]           fetch_pc_reg, fetch_pc_next;
  logic [1:0]            count_reg, count_next;
  logic                  head_reg, head_next;
  logic                  tail_reg, tail_next;
  logic [DATA_WIDTH-1:0] instr_reg [DEPTH];
  logic [31:0]           pc_reg    [DEPTH];

  logic        push;
  logic        pop;
  logic [31:0] redirect_target;
  logic [DEPTH-1:0] slot_we;

  // Word-align the redirect target; the low byte-offset bits carry no meaning.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign rom_addr  = fetch_pc_reg[ADDR_WIDTH+1:2];
  assign out_valid = (count_reg != 2'd0) && !redirect;
  assign out_instr = instr_reg[head_reg];
  assign out_pc    = pc_reg[head_reg];

  assign pop  = out_valid && out_ready;
  assign push = fetch_en && !redirect && ((count_reg != 2'd2) || pop);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
      assign slot_we[gi] = push && (tail_reg == 1'(gi));
    end
  endgenerate

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    count_next    = count_reg;
    head_next     = head_reg;
    tail_next     = tail_reg;
    if (redirect) begin
      // Flush: the queue empties in place, so head catches up with tail.
      fetch_pc_next = redirect_target;
      count_next    = 2'd0;
      head_next     = tail_reg;
    end else begin
      if (push) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
        tail_next     = ~tail_reg;
      end
      if (pop) begin
        head_next = ~head_reg;
      end
      if (push && !pop) begin
        count_next = count_reg + 2'd1;
      end else if (pop && !push) begin
        count_next = count_reg - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fetch_pc_reg <= RESET_PC;
      count_reg    <= 2'd0;
      head_reg     <= 1'b0;
      tail_reg     <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      count_reg    <= count_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_reg[i] <= '0;
        pc_reg[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_we[i]) begin
          instr_reg[i] <= rom_data;
          pc_reg[i]    <= fetch_pc_reg;
        end
      end
    end
  end

endmodule
